cmd_cfg_mc: RTL and testbench



---
 rtl/la_cfg_pkg.sv | 44 ++++
 rtl/cfg_regfile.sv | 105 ++++++++++
 rtl/cmd_cfg_mc.sv | 148 ++++++++++++++
 tb/tb_cmd_cfg_mc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/la_cfg_pkg.sv
// Shared definitions for the logic-analyzer command/configuration processor:
// opcodes, register map, response codes, reset values and FSM state encodings.
package la_cfg_pkg;

  typedef enum logic [1:0] {
    OpRead  = 2'b00,
    OpWrite = 2'b01,
    OpDump  = 2'b10,
    OpNak   = 2'b11
  } opcode_e;

  localparam logic [5:0] AddrTrigCfg   = 6'h00;
  localparam logic [5:0] AddrDecimator = 6'h10;
  localparam logic [5:0] AddrVih       = 6'h11;
  localparam logic [5:0] AddrVil       = 6'h12;
  localparam logic [5:0] AddrMatchH    = 6'h13;
  localparam logic [5:0] AddrMatchL    = 6'h14;
  localparam logic [5:0] AddrMaskH     = 6'h15;
  localparam logic [5:0] AddrMaskL     = 6'h16;
  localparam logic [5:0] AddrBaudH     = 6'h17;
  localparam logic [5:0] AddrBaudL     = 6'h18;
  localparam logic [5:0] AddrTrigPosH  = 6'h19;
  localparam logic [5:0] AddrTrigPosL  = 6'h1A;

  localparam logic [7:0] Ack = 8'hA5;
  localparam logic [7:0] Nak = 8'hEE;

  localparam logic [5:0] RstTrigCfg   = 6'h03;
  localparam logic [4:0] RstChTrig    = 5'h01;
  localparam logic [3:0] RstDecimator = 4'h0;
  localparam logic [7:0] RstVih       = 8'hAA;
  localparam logic [7:0] RstVil       = 8'h55;
  localparam logic [7:0] RstBaudH     = 8'h06;
  localparam logic [7:0] RstBaudL     = 8'hC8;

  typedef logic [2:0] state_t;
  localparam state_t StIdle     = 3'd0;
  localparam state_t StResp     = 3'd1;
  localparam state_t StWait     = 3'd2;
  localparam state_t StDumpRd   = 3'd3;
  localparam state_t StDumpTx   = 3'd4;
  localparam state_t StDumpWait = 3'd5;

endpackage

// File: rtl/cfg_regfile.sv
// Configuration register file: storage, write decode, read mux and the
// sticky capture_done bit in trig_cfg[5].
module cfg_regfile
  import la_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned LOG2   = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [5:0]          addr,
  input  logic [7:0]          wdata,
  input  logic                set_capture_done,
  output logic                hit,
  output logic [7:0]          rd_data,
  output logic [5:0]          trig_cfg,
  output logic [5*NUM_CH-1:0] ch_trig_cfg,
  output logic [3:0]          decimator,
  output logic [7:0]          vih,
  output logic [7:0]          vil,
  output logic [7:0]          match_h,
  output logic [7:0]          match_l,
  output logic [7:0]          mask_h,
  output logic [7:0]          mask_l,
  output logic [7:0]          baud_cnt_h,
  output logic [7:0]          baud_cnt_l,
  output logic [LOG2-1:0]     trig_pos
);

  logic [4:0] ch_q [NUM_CH];
  logic       is_ch;

  assign is_ch = (addr >= 6'd1) && (addr <= 6'(NUM_CH));
  assign hit   = (addr == AddrTrigCfg) || is_ch ||
                 ((addr >= AddrDecimator) && (addr <= AddrTrigPosL));

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_trig_cfg[5*k +: 5] = ch_q[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_cfg   <= RstTrigCfg;
      decimator  <= RstDecimator;
      vih        <= RstVih;
      vil        <= RstVil;
      match_h    <= '0;
      match_l    <= '0;
      mask_h     <= '0;
      mask_l     <= '0;
      baud_cnt_h <= RstBaudH;
      baud_cnt_l <= RstBaudL;
      trig_pos   <= '0;
      for (int k = 0; k < NUM_CH; k++) ch_q[k] <= RstChTrig;
    end else begin
      if (wr_en) begin
        case (addr)
          AddrTrigCfg:   trig_cfg   <= wdata[5:0];
          AddrDecimator: decimator  <= wdata[3:0];
          AddrVih:       vih        <= wdata;
          AddrVil:       vil        <= wdata;
          AddrMatchH:    match_h    <= wdata;
          AddrMatchL:    match_l    <= wdata;
          AddrMaskH:     mask_h     <= wdata;
          AddrMaskL:     mask_l     <= wdata;
          AddrBaudH:     baud_cnt_h <= wdata;
          AddrBaudL:     baud_cnt_l <= wdata;
          AddrTrigPosH:  trig_pos[LOG2-1:8] <= wdata[LOG2-9:0];
          AddrTrigPosL:  trig_pos[7:0]      <= wdata;
          default: ;
        endcase
        for (int k = 0; k < NUM_CH; k++) begin
          if (addr == 6'(k + 1)) ch_q[k] <= wdata[4:0];
        end
      end
      // Capture-done wins over a simultaneous trig_cfg write.
      if (set_capture_done) trig_cfg[5] <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      AddrTrigCfg:   rd_data = {2'b00, trig_cfg};
      AddrDecimator: rd_data = {4'h0, decimator};
      AddrVih:       rd_data = vih;
      AddrVil:       rd_data = vil;
      AddrMatchH:    rd_data = match_h;
      AddrMatchL:    rd_data = match_l;
      AddrMaskH:     rd_data = mask_h;
      AddrMaskL:     rd_data = mask_l;
      AddrBaudH:     rd_data = baud_cnt_h;
      AddrBaudL:     rd_data = baud_cnt_l;
      AddrTrigPosH:  rd_data = 8'(trig_pos[LOG2-1:8]);
      AddrTrigPosL:  rd_data = trig_pos[7:0];
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (addr == 6'(k + 1)) rd_data = {3'b000, ch_q[k]};
        end
      end
    endcase
  end

endmodule

// File: rtl/cmd_cfg_mc.sv
// Multi-channel command processor: decodes host commands, answers register
// accesses and streams any RAM queue as a circular buffer from the capture pointer.
module cmd_cfg_mc
  import la_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH  = 5,
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned LOG2    = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         cmd,
  input  logic                cmd_rdy,
  input  logic                resp_sent,
  input  logic                set_capture_done,
  input  logic [LOG2-1:0]     ram_addr,
  input  logic [8*NUM_CH-1:0] rdata_ch,
  output logic [LOG2-1:0]     addr_ptr,
  output logic [7:0]          resp,
  output logic                send_resp,
  output logic                clr_cmd_rdy,
  output logic [5:0]          trig_cfg,
  output logic [5*NUM_CH-1:0] ch_trig_cfg,
  output logic [3:0]          decimator,
  output logic [7:0]          vih,
  output logic [7:0]          vil,
  output logic [7:0]          match_h,
  output logic [7:0]          match_l,
  output logic [7:0]          mask_h,
  output logic [7:0]          mask_l,
  output logic [7:0]          baud_cnt_h,
  output logic [7:0]          baud_cnt_l,
  output logic [LOG2-1:0]     trig_pos
);

  localparam logic [LOG2-1:0] LastIdx = LOG2'(ENTRIES - 1);

  state_t          state_q;
  logic [LOG2-1:0] cnt_q;
  logic [2:0]      dump_ch_q;
  opcode_e         op;
  logic [5:0]      cmd_addr;
  logic            wr_en, hit, dump_ok;
  logic [7:0]      rd_data, single_resp, dump_byte;

  assign op       = opcode_e'(cmd[15:14]);
  assign cmd_addr = cmd[13:8];
  assign dump_ok  = (op == OpDump) && (cmd_addr >= 6'd1) && (cmd_addr <= 6'(NUM_CH));
  assign wr_en    = (state_q == StIdle) && cmd_rdy && (op == OpWrite);

  cfg_regfile #(
    .NUM_CH (NUM_CH),
    .LOG2   (LOG2)
  ) u_regfile (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .addr             (cmd_addr),
    .wdata            (cmd[7:0]),
    .set_capture_done (set_capture_done),
    .hit              (hit),
    .rd_data          (rd_data),
    .trig_cfg         (trig_cfg),
    .ch_trig_cfg      (ch_trig_cfg),
    .decimator        (decimator),
    .vih              (vih),
    .vil              (vil),
    .match_h          (match_h),
    .match_l          (match_l),
    .mask_h           (mask_h),
    .mask_l           (mask_l),
    .baud_cnt_h       (baud_cnt_h),
    .baud_cnt_l       (baud_cnt_l),
    .trig_pos         (trig_pos)
  );

  always_comb begin
    single_resp = Nak;
    case (op)
      OpRead:  if (hit) single_resp = rd_data;
      OpWrite: if (hit) single_resp = Ack;
      default: single_resp = Nak;
    endcase
  end

  always_comb begin
    dump_byte = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (dump_ch_q == 3'(k + 1)) dump_byte = rdata_ch[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dump_ch_q   <= '0;
      addr_ptr    <= '0;
      resp        <= '0;
      send_resp   <= 1'b0;
      clr_cmd_rdy <= 1'b0;
    end else begin
      send_resp   <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_rdy) begin
            if (dump_ok) begin
              addr_ptr  <= ram_addr;
              cnt_q     <= '0;
              dump_ch_q <= cmd_addr[2:0];
              state_q   <= StDumpRd;
            end else begin
              resp    <= single_resp;
              state_q <= StResp;
            end
          end
        end
        StResp: begin
          send_resp   <= 1'b1;
          clr_cmd_rdy <= 1'b1;
          state_q     <= StWait;
        end
        StWait:   if (resp_sent) state_q <= StIdle;
        StDumpRd: state_q <= StDumpTx;
        StDumpTx: begin
          resp      <= dump_byte;
          send_resp <= 1'b1;
          state_q   <= StDumpWait;
        end
        StDumpWait: begin
          if (resp_sent) begin
            if (cnt_q == LastIdx) begin
              clr_cmd_rdy <= 1'b1;
              state_q     <= StIdle;
            end else begin
              cnt_q    <= cnt_q + 1'b1;
              addr_ptr <= (addr_ptr == LastIdx) ? '0 : addr_ptr + 1'b1;
              state_q  <= StDumpRd;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_cfg_mc.sv
// Scoreboard bench for cmd_cfg_mc: a host model issues commands and pushes the
// expected responses; a monitor pops and compares each byte the DUT sends.
module tb_cmd_cfg_mc;

  localparam int NUM_CH  = 5;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [15:0]         cmd = '0;
  logic                cmd_rdy = 1'b0;
  logic                resp_sent = 1'b0;
  logic                set_capture_done = 1'b0;
  logic [LOG2-1:0]     ram_addr = '0;
  logic [8*NUM_CH-1:0] rdata_ch = '0;
  logic [LOG2-1:0]     addr_ptr;
  logic [7:0]          resp;
  logic                send_resp;
  logic                clr_cmd_rdy;
  logic [5:0]          trig_cfg;
  logic [5*NUM_CH-1:0] ch_trig_cfg;
  logic [3:0]          decimator;
  logic [7:0]          vih, vil, match_h, match_l, mask_h, mask_l, baud_cnt_h, baud_cnt_l;
  logic [LOG2-1:0]     trig_pos;

  cmd_cfg_mc #(
    .NUM_CH  (NUM_CH),
    .ENTRIES (ENTRIES),
    .LOG2    (LOG2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .resp_sent        (resp_sent),
    .set_capture_done (set_capture_done),
    .ram_addr         (ram_addr),
    .rdata_ch         (rdata_ch),
    .addr_ptr         (addr_ptr),
    .resp             (resp),
    .send_resp        (send_resp),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .trig_cfg         (trig_cfg),
    .ch_trig_cfg      (ch_trig_cfg),
    .decimator        (decimator),
    .vih              (vih),
    .vil              (vil),
    .match_h          (match_h),
    .match_l          (match_l),
    .mask_h           (mask_h),
    .mask_l           (mask_l),
    .baud_cnt_h       (baud_cnt_h),
    .baud_cnt_l       (baud_cnt_l),
    .trig_pos         (trig_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] resp;
    logic       clr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   rx_cnt   = 0;

  // Channel 3 holds a mod 256; other channels get a distinct pattern.
  function automatic logic [7:0] data_of(input int ch, input int a);
    if (ch == 3) return 8'(a);
    return 8'(a * ch + 8'h5A);
  endfunction

  // Synchronous-read RAM model, one cycle of latency.
  always @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) rdata_ch[8*k +: 8] <= data_of(k + 1, int'(addr_ptr));
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Host transmitter: acknowledges each byte a couple of cycles after it starts.
  initial forever begin
    @(negedge clk);
    if (!rst && send_resp) begin
      repeat (2) @(negedge clk);
      resp_sent = 1'b1;
      @(negedge clk);
      resp_sent = 1'b0;
    end
  end

  // Monitor: every send_resp pops one expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && send_resp) begin
      rx_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_resp", {24'h0, resp}, 32'h1FF);
      end else begin
        e = sb.pop_front();
        check("resp", {24'h0, resp}, {24'h0, e.resp});
        check("clr_with_resp", {31'h0, clr_cmd_rdy}, {31'h0, e.clr});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    logic [5*NUM_CH-1:0] ch_exp;
    for (int k = 0; k < NUM_CH; k++) ch_exp[5*k +: 5] = 5'h01;
    check({tag, "_resp"}, {24'h0, resp}, 32'h0);
    check({tag, "_addr_ptr"}, {23'h0, addr_ptr}, 32'h0);
    check({tag, "_send_resp"}, {31'h0, send_resp}, 32'h0);
    check({tag, "_clr_cmd_rdy"}, {31'h0, clr_cmd_rdy}, 32'h0);
    check({tag, "_trig_cfg"}, {26'h0, trig_cfg}, 32'h03);
    check({tag, "_ch_trig_cfg"}, {7'h0, ch_trig_cfg}, {7'h0, ch_exp});
    check({tag, "_decimator"}, {28'h0, decimator}, 32'h0);
    check({tag, "_vih_vil"}, {16'h0, vih, vil}, 32'hAA55);
    check({tag, "_match_mask"}, {match_h, match_l, mask_h, mask_l}, 32'h0);
    check({tag, "_baud"}, {16'h0, baud_cnt_h, baud_cnt_l}, 32'h06C8);
    check({tag, "_trig_pos"}, {23'h0, trig_pos}, 32'h0);
  endtask

  task automatic wait_clr(input int limit, input string nm);
    int t = 0;
    while (!clr_cmd_rdy && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (!clr_cmd_rdy) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: no clr_cmd_rdy within %0d cycles", nm, limit);
    end
  endtask

  task automatic send_cmd(input logic [15:0] c, input logic [7:0] exp, input logic scd);
    sb.push_back('{exp, 1'b1});
    @(negedge clk);
    cmd = c;
    cmd_rdy = 1'b1;
    set_capture_done = scd;
    @(negedge clk);
    set_capture_done = 1'b0;
    wait_clr(50, $sformatf("cmd_%04h_timeout", c));
    cmd_rdy = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int base;
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("por");

    send_cmd(16'h1100, 8'hAA, 1'b0);
    send_cmd(16'h1700, 8'h06, 1'b0);

    send_cmd(16'h55AF, 8'hA5, 1'b0);
    check("mask_h_written", {24'h0, mask_h}, 32'hAF);
    send_cmd(16'h1500, 8'hAF, 1'b0);

    send_cmd(16'h7F12, 8'hEE, 1'b0);
    send_cmd(16'h4BAF, 8'hEE, 1'b0);
    check("unmapped_write_no_change", {mask_h, vih, 2'b00, trig_cfg, 4'h0, decimator},
          {8'hAF, 8'hAA, 8'h03, 8'h00});
    send_cmd(16'hC000, 8'hEE, 1'b0);
    send_cmd(16'h3F00, 8'hEE, 1'b0);
    send_cmd(16'h0600, 8'hEE, 1'b0);

    // Field truncation: trig_pos_h keeps 1 bit, decimator 4, ch_trig 5.
    send_cmd(16'h59FF, 8'hA5, 1'b0);
    send_cmd(16'h5A34, 8'hA5, 1'b0);
    check("trig_pos", {23'h0, trig_pos}, 32'h134);
    send_cmd(16'h1900, 8'h01, 1'b0);
    send_cmd(16'h50FF, 8'hA5, 1'b0);
    send_cmd(16'h1000, 8'h0F, 1'b0);
    send_cmd(16'h45FF, 8'hA5, 1'b0);
    check("ch5_trig_cfg", {27'h0, ch_trig_cfg[24:20]}, 32'h1F);
    send_cmd(16'h0500, 8'h1F, 1'b0);
    send_cmd(16'h0100, 8'h01, 1'b0);

    // Wrapping dump of channel 3 from the capture pointer.
    ram_addr = 9'd380;
    for (int i = 0; i < ENTRIES; i++) sb.push_back('{data_of(3, (380 + i) % ENTRIES), 1'b0});
    base = rx_cnt;
    @(negedge clk);
    cmd = 16'h8300;
    cmd_rdy = 1'b1;
    wait_clr(20000, "dump_ch3_timeout");
    check("dump_ch3_len_at_clr", rx_cnt - base, ENTRIES);
    cmd_rdy = 1'b0;
    repeat (4) @(negedge clk);
    check("dump_ch3_queue_drained", sb.size(), 0);

    send_cmd(16'h4000, 8'hA5, 1'b1);
    check("capture_done_wins", {26'h0, trig_cfg}, 32'h20);
    send_cmd(16'h0000, 8'h20, 1'b0);
    send_cmd(16'h8600, 8'hEE, 1'b0);
    send_cmd(16'h8000, 8'hEE, 1'b0);

    // Reset partway through a dump of channel 1.
    ram_addr = 9'd5;
    for (int i = 0; i < ENTRIES; i++) sb.push_back('{data_of(1, (5 + i) % ENTRIES), 1'b0});
    base = rx_cnt;
    @(negedge clk);
    cmd = 16'h8100;
    cmd_rdy = 1'b1;
    t = 0;
    while (rx_cnt < base + 10 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("bytes_before_reset", rx_cnt - base, 10);
    rst = 1'b1;
    cmd_rdy = 1'b0;
    #1;
    check_reset_outputs("mid_dump_rst");
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd(16'h0000, 8'h03, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
